// File: rtl/mem_pkg.sv
// Shared defaults and helpers for the mem register-file RAM.
package mem_pkg;

    localparam int MEM_DEF_WIDTH  = 4;
    localparam int MEM_DEF_ADDR_W = 4;

    function automatic int mem_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/mem_if.sv
// Bus bundle for the mem RAM: master drives address/data/enable, slave returns read data.
// Handshake: no valid/ready; a write is accepted on every rising clk edge where we=1.
interface mem_if #(
    parameter int WIDTH  = mem_pkg::MEM_DEF_WIDTH,
    parameter int ADDR_W = mem_pkg::MEM_DEF_ADDR_W
);

    logic [WIDTH-1:0]  z;
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] address;
    logic              we;

    modport master (
        output in,
        output address,
        output we,
        input  z
    );

    modport slave (
        input  in,
        input  address,
        input  we,
        output z
    );

endinterface

// File: rtl/mem.sv
// Single-port RAM: synchronous write, combinational read (registered read when MEM_OUT_REG_EN is defined).
// Asynchronous active-low reset clears every word.
module mem
    import mem_pkg::*;
#(
    parameter int WIDTH  = MEM_DEF_WIDTH,
    parameter int ADDR_W = MEM_DEF_ADDR_W
) (
    output logic [WIDTH-1:0]  z,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              we,
    input  logic              clk,
    input  logic              rst_n
);

    localparam int DEPTH = mem_depth(ADDR_W);

    logic [WIDTH-1:0] word [DEPTH];

    // Per-word compare: an unknown we or address never matches, so other words stay intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                word[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we && (address == ADDR_W'(i))) begin
                    word[i] <= in;
                end
            end
        end
    end

`ifdef MEM_OUT_REG_EN
    // Samples the array before this edge's write lands, giving read-old-data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= '0;
        end else begin
            z <= word[address];
        end
    end
`else
    always_comb begin
        z = word[address];
    end
`endif

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed cases plus random write/read traffic against an array model.
module tb_mem;

    localparam int W     = 4;
    localparam int A     = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    mem_if #(.WIDTH(W), .ADDR_W(A)) bus ();

    mem #(.WIDTH(W), .ADDR_W(A)) dut (
        .z       (bus.z),
        .in      (bus.in),
        .address (bus.address),
        .we      (bus.we),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] model [DEPTH];
    logic [W-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic write_word(input logic [A-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        bus.address = a;
        bus.in      = d;
        bus.we      = 1'b1;
        @(posedge clk);
        model[a] = d;
    endtask

    task automatic read_chk(input string tag, input logic [A-1:0] a);
        logic [W-1:0] exp;
        @(negedge clk);
        bus.address = a;
        bus.we      = 1'b0;
        bus.in      = W'($urandom_range(0, 15));
        exp_q.push_back(model[a]);
`ifdef MEM_OUT_REG_EN
        @(posedge clk);
`endif
        #1;
        exp = exp_q.pop_front();
        check_eq(tag, bus.z, exp);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) read_chk(tag, A'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b1;
        bus.address = '0;
        bus.in      = '0;
        bus.we      = 1'b0;
        clear_model();

        // Reset asserted with no clock edge yet
        #2 rst_n = 1'b0;
        #1 check_eq("reset_z", bus.z, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("reset_sweep");

        // Basic write/read
        write_word(4'd10, 4'd7);
        read_chk("basic_10", 4'd10);

        // Write disabled over several edges
        @(negedge clk);
        bus.address = 4'd9;
        bus.in      = 4'd4;
        bus.we      = 1'b0;
        repeat (3) @(posedge clk);
        read_chk("wdis_9", 4'd9);
        read_chk("wdis_10", 4'd10);

        // Read timing around a same-address write
        @(negedge clk);
        bus.address = 4'd3;
        bus.in      = 4'd5;
        bus.we      = 1'b1;
`ifndef MEM_OUT_REG_EN
        #1 check_eq("rdw_before", bus.z, 4'd0);
`endif
        @(posedge clk);
        #1;
`ifdef MEM_OUT_REG_EN
        check_eq("rdw_old", bus.z, 4'd0);
        @(negedge clk);
        bus.we = 1'b0;
        @(posedge clk);
        #1;
`endif
        check_eq("rdw_after", bus.z, 4'd5);
        model[3] = 4'd5;

        // Boundary addresses
        write_word(4'd0, 4'd15);
        write_word(4'd15, 4'd1);
        sweep("boundary");

        // Random traffic
        for (int n = 0; n < 120; n++) begin
            logic [A-1:0] a;
            a = A'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) write_word(a, W'($urandom_range(0, 15)));
            else read_chk("rand_rd", a);
        end
        sweep("rand_sweep");

        // Async reset between edges, then a write attempt while held in reset
        write_word(4'd6, 4'd11);
        read_chk("pre_async", 4'd6);
        #2 rst_n = 1'b0;
        #1 check_eq("async_clr", bus.z, '0);
        clear_model();
        @(negedge clk);
        bus.address = 4'd5;
        bus.in      = 4'd9;
        bus.we      = 1'b1;
        @(posedge clk);
        #1 check_eq("rst_wr_block", bus.z, '0);
        @(negedge clk);
        bus.we = 1'b0;
        rst_n  = 1'b1;
        read_chk("post_rst_5", 4'd5);
        sweep("post_rst_sweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
